adc_spi_responder: RTL

Synthesizable SPI responder that emulates the board's 8-channel, 12-bit serial ADC (ADC128S022 framing) at the far end of the ADC SPI link. It oversamples ADC_CS_N/ADC_SCLK/ADC_DIN on the system clock, decodes the channel address, and shifts the selected channel's value out on ADC_DOUT. Channel values are written by the CPU through the memory-mapped IO bus. It is used in simulation and on loop-back builds to exercise the ADC master without the physical converter.

---
 rtl/adc_pkg.sv | 36 +++
 rtl/adc_pin_sync.sv | 34 +++
 rtl/adc_spi_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared constants, register map and types for the ADC SPI responder.
package adc_pkg;

  localparam int unsigned NUM_CH     = 8;
  localparam int unsigned CH_W       = 3;
  localparam int unsigned DATA_W     = 12;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned FCNT_W     = 8;

  // Rising SCLK edge numbers carrying ADD2, ADD1, ADD0.
  localparam int unsigned ADD2_EDGE  = 3;
  localparam int unsigned ADD1_EDGE  = 4;
  localparam int unsigned ADD0_EDGE  = 5;

  // Byte offsets from the base address.
  localparam int unsigned OFF_CH0      = 32'h00;
  localparam int unsigned OFF_STATUS   = 32'h20;
  localparam int unsigned OFF_MISC     = 32'h24;
  localparam int unsigned WINDOW_BYTES = 32'h28;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // STATUS register layout.
  typedef struct packed {
    logic [14:0]       rsvd_hi;
    logic              active;
    logic [FCNT_W-1:0] frame_cnt;
    logic [4:0]        rsvd_lo;
    logic [CH_W-1:0]   next_ch;
  } status_t;

endpackage

// File: rtl/adc_pin_sync.sv
// Two-flop synchronizer with a third delay flop for edge detection.
module adc_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_s1;
  logic r_s2;
  logic r_d3;

  // Synchronize the pin and keep one extra stage for edge compare.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
      r_d3 <= RST_VAL;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
      r_d3 <= r_s2;
    end
  end

  assign o_level  = r_s2;
  assign o_rise_c = r_s2 & ~r_d3;
  assign o_fall_c = ~r_s2 & r_d3;

endmodule

// File: rtl/adc_spi_responder.sv
// Emulates an 8-channel 12-bit serial ADC on the SPI link; channel values
// are written by the CPU over the memory-mapped IO bus.
module adc_spi_responder
  import adc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF1100
) (
  input  logic        iCLK,
  input  logic        Reset,
  input  logic        ADC_CS_N,
  input  logic        ADC_SCLK,
  input  logic        ADC_DIN,
  output logic        ADC_DOUT,
  input  logic        wReadEnable,
  input  logic        wWriteEnable,
  input  logic [3:0]  wByteEnable,
  input  logic [31:0] wAddress,
  input  logic [31:0] wWriteData,
  output logic [31:0] wReadData
);

  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_din_lvl, w_din_rise, w_din_fall;

  adc_pin_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .i_clk(iCLK), .i_rst_n(Reset), .i_pin(ADC_CS_N),
    .o_level(w_cs_lvl), .o_rise_c(w_cs_rise), .o_fall_c(w_cs_fall)
  );

  adc_pin_sync #(.RST_VAL(1'b1)) u_sync_sclk (
    .i_clk(iCLK), .i_rst_n(Reset), .i_pin(ADC_SCLK),
    .o_level(w_sclk_lvl), .o_rise_c(w_sclk_rise), .o_fall_c(w_sclk_fall)
  );

  adc_pin_sync #(.RST_VAL(1'b0)) u_sync_din (
    .i_clk(iCLK), .i_rst_n(Reset), .i_pin(ADC_DIN),
    .o_level(w_din_lvl), .o_rise_c(w_din_rise), .o_fall_c(w_din_fall)
  );

  state_e                r_state, w_state_nxt;
  logic [DATA_W-1:0]     r_ch [NUM_CH];
  logic [FRAME_BITS-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [CH_W-1:0]       r_pend, w_pend_nxt;
  logic [CH_W-1:0]       r_next_ch, w_next_ch_nxt, w_load_ch;
  logic [FCNT_W-1:0]     r_frame_cnt, w_frame_cnt_nxt;
  logic                  r_dout, w_dout_nxt;
  logic                  w_load;

  logic [31:0]           w_off;
  logic [3:0]            w_word;
  logic                  w_in_win;
  logic                  w_ch_hit;
  status_t               w_status;

  // Status bits and pin-sync outputs this block does not consume.
  logic w_unused;
  assign w_unused = ^{wByteEnable[3:2], wWriteData[31:12], w_cs_lvl,
                      w_sclk_lvl, w_din_rise, w_din_fall};

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // FSM state register.
  always_ff @(posedge iCLK or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, frame sequencing, address capture and shift control.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_cnt;
    w_pend_nxt      = r_pend;
    w_next_ch_nxt   = r_next_ch;
    w_frame_cnt_nxt = r_frame_cnt;
    w_load          = 1'b0;
    w_load_ch       = r_next_ch;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_SHIFT;
          w_load      = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sclk_rise) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(ADD2_EDGE)) w_pend_nxt[2] = w_din_lvl;
          if (w_cnt_inc == CNT_W'(ADD1_EDGE)) w_pend_nxt[1] = w_din_lvl;
          if (w_cnt_inc == CNT_W'(ADD0_EDGE)) w_pend_nxt[0] = w_din_lvl;
          if (r_cnt == CNT_W'(FRAME_BITS - 1)) begin
            w_next_ch_nxt = r_pend;
            w_load_ch     = r_pend;
            w_load        = 1'b1;
          end
        end else if (w_sclk_fall && (r_cnt != '0)) begin
          w_shift_nxt = {r_shift[FRAME_BITS-2:0], 1'b0};
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Frame start: reads the register value before any same-cycle bus write.
    if (w_load) begin
      w_shift_nxt     = FRAME_BITS'(r_ch[w_load_ch]);
      w_cnt_nxt       = '0;
      w_pend_nxt      = '0;
      w_frame_cnt_nxt = r_frame_cnt + FCNT_W'(1);
    end
    w_dout_nxt = (w_state_nxt == ST_SHIFT) ? w_shift_nxt[FRAME_BITS-1] : 1'b0;
  end

  // Serial datapath registers.
  always_ff @(posedge iCLK or negedge Reset) begin
    if (!Reset) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_pend      <= '0;
      r_next_ch   <= '0;
      r_frame_cnt <= '0;
      r_dout      <= 1'b0;
    end else begin
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend      <= w_pend_nxt;
      r_next_ch   <= w_next_ch_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_dout      <= w_dout_nxt;
    end
  end

  assign ADC_DOUT = r_dout;

  // Bus address decode within the register window.
  always_comb begin
    w_off    = wAddress - (BASE_ADDR + 32'(OFF_CH0));
    w_in_win = (w_off < 32'(WINDOW_BYTES));
    w_word   = w_off[5:2];
    w_ch_hit = w_in_win && (w_word < 4'(NUM_CH));
  end

  // Channel registers with per-lane write enables.
  always_ff @(posedge iCLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(NUM_CH); i++) r_ch[i] <= '0;
    end else if (wWriteEnable && w_ch_hit) begin
      if (wByteEnable[0]) r_ch[w_word[CH_W-1:0]][7:0]  <= wWriteData[7:0];
      if (wByteEnable[1]) r_ch[w_word[CH_W-1:0]][11:8] <= wWriteData[11:8];
    end
  end

  // Combinational read mux.
  always_comb begin
    w_status           = '0;
    w_status.next_ch   = r_next_ch;
    w_status.frame_cnt = r_frame_cnt;
    w_status.active    = (r_state == ST_SHIFT);
    wReadData          = '0;
    if (wReadEnable && w_in_win) begin
      if (w_ch_hit)                                  wReadData = 32'(r_ch[w_word[CH_W-1:0]]);
      else if (w_word == 4'(OFF_STATUS >> 2))        wReadData = w_status;
      else if (w_word == 4'(OFF_MISC >> 2))          wReadData = '0;
    end
  end

endmodule
